life_ctrl: RTL and testbench

Sequencer that sits directly upstream of the life torus array and drives its `seed`, `seed_ena` and `life_step` inputs. It serially loads a pseudo-random pattern from an internal LFSR through the torus shift chain. It then issues generation steps at a programmable rate. It reads back the torus state vector to detect extinction or still life, and can automatically reseed when either occurs.

---
 rtl/life_ctrl.sv | 166 ++++++++++++++++
 tb/tb_life_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/life_ctrl.sv
// Seed/step sequencer for the life torus: LFSR serial load, timed generation steps,
// and dead/still-life detection with optional automatic reseed.
module life_ctrl #(
    parameter int          TORUS_WIDTH  = 32,
    parameter int          TORUS_HEIGHT = 16,
    parameter int          STEP_DIV     = 12500000,
    parameter logic [15:0] LFSR_INIT    = 16'hACE1,
    parameter bit          AUTO_RESEED  = 1'b1
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic                                pause,
    input  logic [TORUS_WIDTH*TORUS_HEIGHT-1:0] torusv,
    output logic                                seed,
    output logic                                seed_ena,
    output logic                                life_step,
    output logic                                loading,
    output logic [15:0]                         generation,
    output logic                                stalled
);

    localparam int N  = TORUS_WIDTH * TORUS_HEIGHT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(STEP_DIV);
    localparam logic [CW-1:0] LOAD_LAST  = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_DIV - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t          state_r;
    logic [15:0]     lfsr_r;
    logic [CW-1:0]   load_cnt_r;
    logic [TW-1:0]   timer_r;
    logic [N-1:0]    snap_r;
    logic            snap_valid_r;
    logic            check_r;

    logic            dead_s;
    logic            still_s;
    logic            stall_hit_s;
    logic            enter_load_s;
    logic            reseed_s;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    assign dead_s      = (torusv == {N{1'b0}});
    assign still_s     = snap_valid_r && (torusv == snap_r);
    assign stall_hit_s = check_r && (dead_s || still_s);

    // Decide whether this edge starts a (re)load; a start request outranks everything in RUN.
    always_comb begin
        enter_load_s = 1'b0;
        reseed_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                enter_load_s = start;
            end
            S_RUN: begin
                if (start) begin
                    enter_load_s = 1'b1;
                end else if (stall_hit_s && AUTO_RESEED) begin
                    enter_load_s = 1'b1;
                    reseed_s     = 1'b1;
                end else begin
                    enter_load_s = 1'b0;
                end
            end
            default: begin
                enter_load_s = 1'b0;
            end
        endcase
    end

    // Sequencer state, LFSR, counters, snapshot and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            lfsr_r       <= LFSR_INIT;
            load_cnt_r   <= '0;
            timer_r      <= '0;
            snap_r       <= '0;
            snap_valid_r <= 1'b0;
            check_r      <= 1'b0;
            seed         <= 1'b0;
            seed_ena     <= 1'b0;
            life_step    <= 1'b0;
            loading      <= 1'b0;
            generation   <= 16'd0;
            stalled      <= 1'b0;
        end else begin
            life_step <= 1'b0;
            if (enter_load_s) begin
                // The entry edge already presents the first seed bit.
                state_r      <= S_LOAD;
                seed_ena     <= 1'b1;
                loading      <= 1'b1;
                seed         <= lfsr_r[0];
                lfsr_r       <= lfsr_next(lfsr_r);
                load_cnt_r   <= '0;
                timer_r      <= '0;
                generation   <= 16'd0;
                snap_valid_r <= 1'b0;
                check_r      <= 1'b0;
                stalled      <= reseed_s;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        seed_ena <= 1'b0;
                        loading  <= 1'b0;
                        seed     <= 1'b0;
                    end
                    S_LOAD: begin
                        if (load_cnt_r == LOAD_LAST) begin
                            // Count this edge as the first timer tick so the
                            // first step lands STEP_DIV cycles after the last seed bit.
                            state_r  <= S_RUN;
                            seed_ena <= 1'b0;
                            loading  <= 1'b0;
                            seed     <= 1'b0;
                            timer_r  <= pause ? '0 : TIMER_ONE;
                        end else begin
                            load_cnt_r <= load_cnt_r + CNT_ONE;
                            seed       <= lfsr_r[0];
                            lfsr_r     <= lfsr_next(lfsr_r);
                        end
                    end
                    S_RUN: begin
                        check_r <= life_step;
                        if (check_r) begin
                            snap_r       <= torusv;
                            snap_valid_r <= 1'b1;
                            if (dead_s || still_s) begin
                                stalled <= 1'b1;
                            end
                        end
                        if (!pause) begin
                            if (timer_r == TIMER_LAST) begin
                                timer_r    <= '0;
                                life_step  <= 1'b1;
                                generation <= generation + 16'd1;
                            end else begin
                                timer_r <= timer_r + TIMER_ONE;
                            end
                        end
                    end
                    default: begin
                        state_r  <= S_IDLE;
                        seed_ena <= 1'b0;
                        loading  <= 1'b0;
                        seed     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_life_ctrl.sv
// Directed bench for life_ctrl on a 4x4 torus with an 8-cycle step period;
// a second instance without auto-reseed runs in lockstep.
module tb_life_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        pause;
    logic [15:0] torusv;
    logic        seed, seed_ena, life_step, loading, stalled;
    logic [15:0] generation;
    logic        seed_b, seed_ena_b, life_step_b, loading_b, stalled_b;
    logic [15:0] generation_b;

    logic        tv_free;
    logic [15:0] tv_fixed;
    logic [15:0] cyc = 16'd0;
    int          checks = 0;
    int          errors = 0;

    life_ctrl #(.TORUS_WIDTH(4), .TORUS_HEIGHT(4), .STEP_DIV(8),
                .LFSR_INIT(16'hACE1), .AUTO_RESEED(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .torusv(torusv),
        .seed(seed), .seed_ena(seed_ena), .life_step(life_step), .loading(loading),
        .generation(generation), .stalled(stalled)
    );

    life_ctrl #(.TORUS_WIDTH(4), .TORUS_HEIGHT(4), .STEP_DIV(8),
                .LFSR_INIT(16'hACE1), .AUTO_RESEED(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .torusv(torusv),
        .seed(seed_b), .seed_ena(seed_ena_b), .life_step(life_step_b), .loading(loading_b),
        .generation(generation_b), .stalled(stalled_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running board content never repeats between checks and is never zero.
    always @(posedge clk) cyc <= cyc + 16'd1;
    assign torusv = tv_free ? (16'h8000 | cyc) : tv_fixed;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_step(input int limit, output int n);
        n = 0;
        while (life_step !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int          n;
        int          cnt;
        logic [15:0] m;
        logic [3:0]  first4;

        reset_n  = 1'b1;
        start    = 1'b0;
        pause    = 1'b0;
        tv_free  = 1'b1;
        tv_fixed = 16'h0000;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_outputs", 32'({seed, seed_ena, life_step, loading, stalled}), 32'd0);
        chk("rst_generation", 32'(generation), 32'd0);
        chk("rst_lfsr", 32'(dut.lfsr_r), 32'h0000ACE1);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Initial load: 16 seed cycles, seed bits follow the LFSR LSB sequence.
        start = 1'b1;
        tick();
        start  = 1'b0;
        m      = 16'hACE1;
        cnt    = 0;
        first4 = 4'd0;
        for (int i = 0; i < 20; i++) begin
            if (seed_ena === 1'b1) cnt++;
            chk("load_seed_ena", 32'(seed_ena), 32'(i < 16));
            chk("load_loading", 32'(loading), 32'(i < 16));
            if (i < 16) begin
                chk("load_seed_bit", 32'(seed), 32'(m[0]));
                m = lfsr_step(m);
            end
            if (i < 4) first4[i] = seed;
            tick();
        end
        chk("load_first4", 32'(first4), 32'h1);
        chk("load_len", 32'(cnt), 32'd16);

        // Step cadence.
        wait_step(10, n);
        chk("step1_latency", 32'(n), 32'd3);
        chk("step1_gen", 32'(generation), 32'd1);
        chk("step1_no_seed", 32'(seed_ena), 32'd0);
        tick();
        chk("step_pulse_width", 32'(life_step), 32'd0);
        wait_step(10, n);
        chk("step2_period", 32'(n), 32'd7);
        chk("step2_gen", 32'(generation), 32'd2);
        tick();
        wait_step(10, n);
        chk("step3_period", 32'(n), 32'd7);
        chk("step3_gen", 32'(generation), 32'd3);
        chk("step3_not_stalled", 32'(stalled), 32'd0);

        // Pause for 5 cycles mid-period.
        tick();
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pause_gen_hold", 32'(generation), 32'd3);
            chk("pause_no_step", 32'(life_step), 32'd0);
        end
        pause = 1'b0;
        wait_step(20, n);
        chk("pause_delay", 32'(n), 32'd7);
        chk("pause_gen", 32'(generation), 32'd4);

        // Extinction: reseed two cycles after the step; the non-reseeding copy keeps running.
        tv_free  = 1'b0;
        tv_fixed = 16'h0000;
        tick();
        chk("dead_check_cycle_stalled", 32'(stalled), 32'd0);
        chk("dead_check_cycle_ena", 32'(seed_ena), 32'd0);
        tick();
        chk("dead_stalled", 32'(stalled), 32'd1);
        chk("dead_reseed_ena", 32'(seed_ena), 32'd1);
        chk("dead_gen_clear", 32'(generation), 32'd0);
        chk("dead_b_stalled", 32'(stalled_b), 32'd1);
        chk("dead_b_no_reseed", 32'(seed_ena_b), 32'd0);
        chk("dead_b_gen", 32'(generation_b), 32'd4);
        tv_free = 1'b1;
        n = 0;
        while (life_step_b !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("dead_b_next_step", 32'(n), 32'd6);
        chk("dead_b_gen_next", 32'(generation_b), 32'd5);
        for (int i = 0; i < 16; i++) m = lfsr_step(m);
        wait_step(30, n);
        chk("reseed_first_step", 32'(n), 32'd17);
        chk("reseed_gen", 32'(generation), 32'd1);

        // Abort in RUN; a start inside the new LOAD must not restart it.
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_gen_clear", 32'(generation), 32'd0);
        chk("abort_stalled_clear", 32'(stalled), 32'd0);
        chk("abort_seed_lfsr_cont", 32'(seed), 32'(m[0]));
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            start = (i == 2);
            if (seed_ena === 1'b1) cnt++;
            chk("abort_seed_ena", 32'(seed_ena), 32'(i < 16));
            tick();
        end
        start = 1'b0;
        chk("abort_load_len", 32'(cnt), 32'd16);

        // Still life: first check records, second detects.
        wait_step(10, n);
        chk("still_first_step", 32'(n), 32'd3);
        chk("still_gen1", 32'(generation), 32'd1);
        tv_free  = 1'b0;
        tv_fixed = 16'h0660;
        tick();
        chk("still_first_check", 32'(stalled), 32'd0);
        wait_step(10, n);
        chk("still_step2", 32'(n), 32'd7);
        chk("still_gen2", 32'(generation), 32'd2);
        tick();
        chk("still_check_cycle", 32'(stalled), 32'd0);
        tick();
        chk("still_stalled", 32'(stalled), 32'd1);
        chk("still_reseed_ena", 32'(seed_ena), 32'd1);
        chk("still_gen_clear", 32'(generation), 32'd0);
        tv_free = 1'b1;

        // Asynchronous reset in the middle of a load.
        tick();
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_outputs", 32'({seed, seed_ena, life_step, loading, stalled}), 32'd0);
        chk("async_rst_gen", 32'(generation), 32'd0);
        chk("async_rst_lfsr", 32'(dut.lfsr_r), 32'h0000ACE1);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("no_resume_ena", 32'(seed_ena), 32'd0);
        chk("no_resume_loading", 32'(loading), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
